// File: rtl/branch_predict_alu_pkg.sv
// Shared types and constants for the branch resolve ALU and its bimodal predictor.
// Mode encoding, funct3 branch conditions, and the predictor reset value.
package branch_predict_alu_pkg;

  typedef enum logic [1:0] {
    MODE_JAL       = 2'd0,
    MODE_JALR      = 2'd1,
    MODE_BRANCH    = 2'd2,
    MODE_INCREMENT = 2'd3
  } BranchALUMode_t;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Weakly-not-taken: one below the taken threshold (0 for single-bit counters).
  function automatic int unsigned bht_weak_not_taken(input int unsigned counter_bits);
    return (32'd1 << (counter_bits - 1)) - 32'd1;
  endfunction

endpackage

// File: rtl/branch_predict_alu_if.sv
// Resolve/fetch bus between decode, the branch ALU, and the fetch PC mux.
// master drives resolve operands and fetchPC; slave is the branch ALU.
interface branch_predict_alu_if
  import branch_predict_alu_pkg::*;
#(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] fetch_pc;
  logic            predict_taken;
  logic            resolve_valid;
  BranchALUMode_t  branch_alu_mode;
  logic [2:0]      funct3;
  logic [XLEN-1:0] immediate_j;
  logic [XLEN-1:0] immediate_i;
  logic [XLEN-1:0] immediate_b;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic [XLEN-1:0] pc_of_instruction;
  logic            predicted_taken;
  logic            result_valid;
  logic [XLEN-1:0] link_value;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            illegal_branch;
  logic [31:0]     branch_count;
  logic [31:0]     mispredict_count;

  modport master (
    output fetch_pc, resolve_valid, branch_alu_mode, funct3, immediate_j, immediate_i,
           immediate_b, rs1, rs2, pc_of_instruction, predicted_taken,
    input  predict_taken, result_valid, link_value, redirect_valid, redirect_pc,
           illegal_branch, branch_count, mispredict_count
  );

  modport slave (
    input  fetch_pc, resolve_valid, branch_alu_mode, funct3, immediate_j, immediate_i,
           immediate_b, rs1, rs2, pc_of_instruction, predicted_taken,
    output predict_taken, result_valid, link_value, redirect_valid, redirect_pc,
           illegal_branch, branch_count, mispredict_count
  );
endinterface

// File: rtl/branch_predict_alu_bht_counter_table.sv
// Bimodal table of saturating counters: one combinational read port, one update port.
// Writes land on the rising edge; a same-cycle read of the written entry sees the old value.
module bht_counter_table
  import branch_predict_alu_pkg::*;
#(
  parameter int ENTRIES      = 64,
  parameter int COUNTER_BITS = 2,
  parameter int IDX_W        = $clog2(ENTRIES)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic             rd_taken_o,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic             wr_taken_i
);
  localparam logic [COUNTER_BITS-1:0] WNT  = COUNTER_BITS'(bht_weak_not_taken(COUNTER_BITS));
  localparam logic [COUNTER_BITS-1:0] CMAX = '1;

  logic [COUNTER_BITS-1:0] cnt_q [ENTRIES];
  logic [COUNTER_BITS-1:0] wr_val_d;

  assign rd_taken_o = cnt_q[rd_idx_i][COUNTER_BITS-1];

  always_comb begin
    wr_val_d = cnt_q[wr_idx_i];
    if (wr_taken_i) begin
      if (wr_val_d != CMAX) wr_val_d = wr_val_d + COUNTER_BITS'(1);
    end else if (wr_val_d != '0) begin
      wr_val_d = wr_val_d - COUNTER_BITS'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= WNT;
    end else if (wr_en_i) begin
      cnt_q[wr_idx_i] <= wr_val_d;
    end
  end

endmodule

// File: rtl/branch_predict_alu.sv
// Branch resolve ALU: computes next PC, flags mispredicts with a registered redirect,
// trains the bimodal predictor, squashes wrong-path resolves, and counts branch events.
module branch_predict_alu
  import branch_predict_alu_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter int BHT_ENTRIES   = 64,
  parameter int COUNTER_BITS  = 2,
  parameter int SQUASH_CYCLES = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  branch_predict_alu_if.slave   bus
);
  localparam int IDX_W = $clog2(BHT_ENTRIES);
  localparam int SQ_W  = (SQUASH_CYCLES > 0) ? $clog2(SQUASH_CYCLES + 1) : 1;

  logic [XLEN-1:0] seq_tgt, jal_tgt, jalr_tgt, br_tgt, redirect_tgt;
  logic            actual_taken, illegal_f3, mispredict, accepted, is_branch;

  logic            result_valid_q, redirect_valid_q, illegal_q;
  logic [XLEN-1:0] link_value_q, redirect_pc_q;
  logic [31:0]     branch_count_q, mispredict_count_q;
  logic [SQ_W-1:0] squash_q;

  assign seq_tgt  = bus.pc_of_instruction + XLEN'(4);
  assign jal_tgt  = bus.pc_of_instruction + bus.immediate_j;
  assign jalr_tgt = (bus.rs1 + bus.immediate_i) & ~XLEN'(1);
  assign br_tgt   = bus.pc_of_instruction + bus.immediate_b;

  assign is_branch = (bus.branch_alu_mode == MODE_BRANCH);
  assign accepted  = bus.resolve_valid && (squash_q == '0);

  always_comb begin
    actual_taken = 1'b0;
    illegal_f3   = 1'b0;
    unique case (bus.funct3)
      F3_BEQ:  actual_taken = (bus.rs1 == bus.rs2);
      F3_BNE:  actual_taken = (bus.rs1 != bus.rs2);
      F3_BLT:  actual_taken = ($signed(bus.rs1) <  $signed(bus.rs2));
      F3_BGE:  actual_taken = ($signed(bus.rs1) >= $signed(bus.rs2));
      F3_BLTU: actual_taken = (bus.rs1 <  bus.rs2);
      F3_BGEU: actual_taken = (bus.rs1 >= bus.rs2);
      default: illegal_f3   = 1'b1;
    endcase
  end

  always_comb begin
    mispredict   = 1'b0;
    redirect_tgt = seq_tgt;
    unique case (bus.branch_alu_mode)
      MODE_JAL: begin
        mispredict   = 1'b1;
        redirect_tgt = jal_tgt;
      end
      MODE_JALR: begin
        mispredict   = 1'b1;
        redirect_tgt = jalr_tgt;
      end
      MODE_BRANCH: begin
        mispredict   = (bus.predicted_taken != actual_taken);
        redirect_tgt = actual_taken ? br_tgt : seq_tgt;
      end
      default: ;
    endcase
  end

  bht_counter_table #(
    .ENTRIES      (BHT_ENTRIES),
    .COUNTER_BITS (COUNTER_BITS),
    .IDX_W        (IDX_W)
  ) u_bht (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .rd_idx_i   (bus.fetch_pc[IDX_W+1:2]),
    .rd_taken_o (bus.predict_taken),
    .wr_en_i    (accepted && is_branch && !illegal_f3),
    .wr_idx_i   (bus.pc_of_instruction[IDX_W+1:2]),
    .wr_taken_i (actual_taken)
  );

  // Result registers are single-cycle pulses: they drop back to 0 without a new accept.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      result_valid_q     <= 1'b0;
      link_value_q       <= '0;
      redirect_valid_q   <= 1'b0;
      redirect_pc_q      <= '0;
      illegal_q          <= 1'b0;
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
      squash_q           <= '0;
    end else begin
      result_valid_q   <= accepted;
      link_value_q     <= accepted ? seq_tgt : '0;
      redirect_valid_q <= accepted && mispredict;
      redirect_pc_q    <= (accepted && mispredict) ? redirect_tgt : '0;
      illegal_q        <= accepted && is_branch && illegal_f3;
      if (accepted && is_branch) begin
        branch_count_q <= branch_count_q + 32'd1;
        if (mispredict) mispredict_count_q <= mispredict_count_q + 32'd1;
      end
      if (accepted && mispredict) begin
        squash_q <= SQ_W'(SQUASH_CYCLES);
      end else if (bus.resolve_valid && (squash_q != '0)) begin
        squash_q <= squash_q - SQ_W'(1);
      end
    end
  end

  assign bus.result_valid     = result_valid_q;
  assign bus.link_value       = link_value_q;
  assign bus.redirect_valid   = redirect_valid_q;
  assign bus.redirect_pc      = redirect_pc_q;
  assign bus.illegal_branch   = illegal_q;
  assign bus.branch_count     = branch_count_q;
  assign bus.mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_predict_alu.sv
// Randomised and directed bench for branch_predict_alu against a behavioural model.
module tb_branch_predict_alu;
  import branch_predict_alu_pkg::*;

  localparam int SQ = 1;

  logic clk;
  logic rst;
  int   vec_cnt = 0;
  int   err_cnt = 0;

  branch_predict_alu_if #(.XLEN(32)) bus();

  branch_predict_alu #(
    .XLEN(32), .BHT_ENTRIES(64), .COUNTER_BITS(2), .SQUASH_CYCLES(SQ)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state
  int unsigned m_bht [64];
  int          m_squash;
  logic [31:0] m_bc, m_mc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_bht[i] = 1;
    m_squash = 0;
    m_bc     = 0;
    m_mc     = 0;
  endtask

  // Reset cycle carrying a live-looking JAL that must be discarded.
  task automatic do_reset();
    @(negedge clk);
    rst                   = 1'b1;
    bus.resolve_valid     = 1'b1;
    bus.branch_alu_mode   = MODE_JAL;
    bus.pc_of_instruction = 32'h500;
    bus.immediate_j       = 32'h40;
    @(posedge clk); #1;
    model_reset();
    chk("rst_result_valid", bus.result_valid, 0);
    chk("rst_link", bus.link_value, 0);
    chk("rst_redirect_valid", bus.redirect_valid, 0);
    chk("rst_redirect_pc", bus.redirect_pc, 0);
    chk("rst_illegal", bus.illegal_branch, 0);
    chk("rst_branch_count", bus.branch_count, 0);
    chk("rst_mispredict_count", bus.mispredict_count, 0);
  endtask

  task automatic step(input bit rv, input BranchALUMode_t md, input logic [2:0] f3,
                      input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] pc,
                      input logic [31:0] ij, input logic [31:0] ii, input logic [31:0] ib,
                      input bit pt);
    bit          acc, taken, illegal, mis, e_redir;
    logic [31:0] seq, tgt;
    int          idx;
    @(negedge clk);
    rst                   = 1'b0;
    bus.resolve_valid     = rv;
    bus.branch_alu_mode   = md;
    bus.funct3            = f3;
    bus.rs1               = r1;
    bus.rs2               = r2;
    bus.pc_of_instruction = pc;
    bus.fetch_pc          = pc;
    bus.immediate_j       = ij;
    bus.immediate_i       = ii;
    bus.immediate_b       = ib;
    bus.predicted_taken   = pt;
    idx = int'(pc[7:2]);
    #1 chk("predict_taken", bus.predict_taken, (m_bht[idx] >= 2) ? 1 : 0);

    seq     = pc + 4;
    illegal = 0;
    case (f3)
      3'b000:  taken = (r1 == r2);
      3'b001:  taken = (r1 != r2);
      3'b100:  taken = ($signed(r1) < $signed(r2));
      3'b101:  taken = !($signed(r1) < $signed(r2));
      3'b110:  taken = (r1 < r2);
      3'b111:  taken = !(r1 < r2);
      default: begin taken = 0; illegal = 1; end
    endcase
    acc = rv && (m_squash == 0);
    case (md)
      MODE_JAL:    begin mis = 1; tgt = pc + ij; end
      MODE_JALR:   begin mis = 1; tgt = {r1[31:1] + ii[31:1] + 31'(r1[0] & ii[0]), 1'b0}; end
      MODE_BRANCH: begin mis = (pt != taken); tgt = taken ? pc + ib : seq; end
      default:     begin mis = 0; tgt = seq; end
    endcase
    e_redir = acc && mis;

    if (acc && md == MODE_BRANCH) begin
      m_bc++;
      if (mis) m_mc++;
      if (!illegal) begin
        if (taken && m_bht[idx] < 3) m_bht[idx]++;
        else if (!taken && m_bht[idx] > 0) m_bht[idx]--;
      end
    end
    if (e_redir) m_squash = SQ;
    else if (rv && m_squash > 0) m_squash--;

    @(posedge clk); #1;
    chk("result_valid", bus.result_valid, acc);
    chk("link_value", bus.link_value, acc ? seq : 0);
    chk("redirect_valid", bus.redirect_valid, e_redir);
    chk("redirect_pc", bus.redirect_pc, e_redir ? tgt : 0);
    chk("illegal_branch", bus.illegal_branch, acc && md == MODE_BRANCH && illegal);
    chk("branch_count", bus.branch_count, m_bc);
    chk("mispredict_count", bus.mispredict_count, m_mc);
  endtask

  initial begin
    logic [31:0] vals [5];
    rst = 1'b1;
    bus.resolve_valid = 0; bus.branch_alu_mode = MODE_INCREMENT; bus.funct3 = 0;
    bus.rs1 = 0; bus.rs2 = 0; bus.pc_of_instruction = 0; bus.fetch_pc = 32'h100;
    bus.immediate_j = 0; bus.immediate_i = 0; bus.immediate_b = 0; bus.predicted_taken = 0;
    model_reset();
    do_reset();
    chk("tp_reset_predict", bus.predict_taken, 0);

    // Mispredicted taken beq, then the squashed follower
    step(1, MODE_BRANCH, F3_BEQ, 5, 5, 32'h100, 0, 0, 32'h20, 0);
    chk("tp_beq_redirect_valid", bus.redirect_valid, 1);
    chk("tp_beq_redirect_pc", bus.redirect_pc, 32'h120);
    chk("tp_beq_bc", bus.branch_count, 1);
    chk("tp_beq_mc", bus.mispredict_count, 1);
    step(1, MODE_BRANCH, F3_BEQ, 5, 5, 32'h100, 0, 0, 32'h20, 1);
    chk("tp_squashed", bus.result_valid, 0);
    step(1, MODE_BRANCH, F3_BEQ, 5, 5, 32'h100, 0, 0, 32'h20, 1);
    chk("tp_trained_predict", bus.predict_taken, 1);
    step(1, MODE_BRANCH, F3_BEQ, 7, 7, 32'h100, 0, 0, 32'h20, 1);
    chk("tp_correct_no_redirect", bus.redirect_valid, 0);

    step(1, MODE_JALR, F3_BEQ, 32'h203, 0, 32'h300, 0, 4, 0, 0);
    chk("tp_jalr_pc", bus.redirect_pc, 32'h206);
    chk("tp_jalr_link", bus.link_value, 32'h304);
    step(1, MODE_INCREMENT, F3_BEQ, 0, 0, 32'h304, 0, 0, 0, 0);
    step(1, MODE_JAL, F3_BEQ, 0, 0, 32'h40, 32'hFFFF_FFF8, 0, 0, 0);
    chk("tp_jal_pc", bus.redirect_pc, 32'h38);
    step(1, MODE_INCREMENT, F3_BEQ, 0, 0, 32'h38, 0, 0, 0, 0);

    step(1, MODE_BRANCH, F3_BLTU, 32'hFFFF_FFFF, 1, 32'h80, 0, 0, 32'h10, 0);
    chk("tp_bltu_not_taken", bus.redirect_valid, 0);
    step(1, MODE_BRANCH, F3_BLT, 32'hFFFF_FFFF, 1, 32'h80, 0, 0, 32'h10, 0);
    chk("tp_blt_taken_pc", bus.redirect_pc, 32'h90);
    step(1, MODE_INCREMENT, F3_BEQ, 0, 0, 32'h84, 0, 0, 0, 0);
    step(1, MODE_BRANCH, 3'b010, 3, 3, 32'h80, 0, 0, 32'h10, 0);
    chk("tp_illegal", bus.illegal_branch, 1);
    step(1, MODE_BRANCH, 3'b011, 3, 3, 32'h80, 0, 0, 32'h10, 1);
    chk("tp_illegal_not_taken", bus.redirect_pc, 32'h84);

    // Reset during a squash window
    step(1, MODE_JAL, F3_BEQ, 0, 0, 32'h200, 32'h100, 0, 0, 0);
    do_reset();
    step(1, MODE_INCREMENT, F3_BEQ, 0, 0, 32'h10, 0, 0, 0, 0);
    chk("tp_accept_after_reset", bus.result_valid, 1);

    vals[0] = 0; vals[1] = 1; vals[2] = 5; vals[3] = 32'hFFFF_FFFF; vals[4] = 32'h8000_0000;
    for (int n = 0; n < 600; n++) begin
      logic [31:0] pc;
      logic [2:0]  f3;
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        pc = ($urandom_range(0, 3) == 0) ? $urandom() : (32'($urandom_range(0, 15)) << 2);
        f3 = 3'($urandom_range(0, 7));
        step($urandom_range(0, 4) != 0, BranchALUMode_t'(2'($urandom_range(0, 3))), f3,
             vals[$urandom_range(0, 4)], vals[$urandom_range(0, 4)], pc,
             $urandom(), $urandom(), $urandom(), 1'($urandom_range(0, 1)));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/branch_predict_alu.md
# branch_predict_alu

Parametrised successor to the core's combinational branch ALU. It resolves JAL/JALR/conditional branches/sequential increments, compares the actual next PC against the fetch stage's prediction, and drives a registered redirect. It owns a bimodal branch history table (BHT) of saturating counters that supplies fetch-time predictions, a post-redirect squash window, and performance counters. It sits between decode/register read and the fetch PC mux.

## Interface
- XLEN, 32: datapath width.
- BHT_ENTRIES, 64: predictor entries; power of two, ≥2.
- COUNTER_BITS, 2: saturating counter width, ≥1.
- SQUASH_CYCLES, 1: number of resolveValid inputs dropped after a redirect; 0 disables squashing.
- clock  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- fetchPC  in  XLEN  PC being fetched.
- predictTaken  out  1  combinational; MSB of BHT[fetchPC index].
- resolveValid  in  1  resolve inputs valid this cycle.
- branchALUMode  in  BranchALUMode_t  JAL / JALR / BRANCH / INCREMENT.
- funct3  in  3  branch condition.
- immediateJ, immediateI, immediateB  in  XLEN each  sign-extended immediates.
- rs1, rs2, pcOfInstruction  in  XLEN each  operands and instruction PC.
- predictedTaken  in  1  prediction fetch used for this instruction.
- resultValid  out  1  registered; resolve accepted last cycle.
- linkValue  out  XLEN  registered; pcOfInstruction+4.
- redirectValid  out  1  registered; misprediction, fetch must load redirectPC.
- redirectPC  out  XLEN  registered; correct next PC.
- illegalBranch  out  1  registered; BRANCH with funct3 010/011.
- branchCount, mispredictCount  out  32 each  performance counters.

## Operation
- Targets: seq = pc+4; JAL = pc+immJ; JALR = (rs1+immI) with bit 0 cleared; BR = pc+immB. All arithmetic is modulo 2^XLEN.
- Conditions: 000 eq, 001 ne, 100 signed lt, 101 signed ge, 110 unsigned lt, 111 unsigned ge. 010/011 give actualTaken=0 and set illegalBranch.
- Accepted = resolveValid && squashCount==0. A non-accepted input has no effect apart from decrementing squashCount when resolveValid is high.
- Mispredict on an accepted input:
  - JAL: always; redirectPC = JAL target.
  - JALR: always; redirectPC = JALR target.
  - BRANCH: when predictedTaken != actualTaken; redirectPC = actualTaken ? BR : seq.
  - INCREMENT: never.
- On a mispredict, squashCount loads SQUASH_CYCLES.
- BHT index = pc[log2(BHT_ENTRIES)+1:2].
- BHT update: on an accepted BRANCH with legal funct3, increment the counter if taken, otherwise decrement, saturating at 0 and 2^COUNTER_BITS−1.
- branchCount increments on every accepted BRANCH, including illegal ones. mispredictCount increments on every BRANCH mispredict. JAL/JALR redirects are not counted. Both counters wrap at 2^32.

## Timing
- Resolve latency is 1 cycle: inputs accepted at edge N appear on resultValid/linkValue/redirect*/illegalBranch after edge N.
- Those registered outputs are valid for exactly one cycle and read 0 on the next cycle unless a new input is accepted.
- predictTaken has 0 latency.
- A BHT write at edge N is visible to predictTaken after edge N. A same-cycle read of the entry being written returns the old value; there is no bypass.
- squashCount is decremented only by resolveValid=1 cycles, not by idle cycles.
- Reset, including mid-squash or mid-update:
  - All registered outputs, both perf counters and squashCount clear to 0.
  - Every BHT entry loads weakly-not-taken, 2^(COUNTER_BITS−1)−1; with COUNTER_BITS=1 this is 0.
  - The resolve input present in the reset cycle is discarded.

## Structure
- BranchALUMode_t already lives in JZJCoreFTypes.
- Add to that package: funct3 encodings as named localparams and a BHT weak-not-taken constant function.
- Sub-module: bht_counter_table (counter array, read port, saturating update port).
- Target computation and condition compare stay inline.

## Test plan
- Reset, then fetchPC=0x100 → predictTaken=0; all outputs and counters 0.
- BRANCH beq at pc=0x100, rs1=rs2=5, immB=0x20, predictedTaken=0:
  - Next cycle: redirectValid=1, redirectPC=0x120, branchCount=1, mispredictCount=1.
  - The following resolveValid is squashed (resultValid stays 0).
- Two taken beq at 0x100 → BHT[0x100] reaches 3. Then fetchPC=0x100 → predictTaken=1. Then a taken beq with predictedTaken=1 → redirectValid=0.
- JALR with rs1=0x203, immI=4 → redirectPC=0x206, linkValue=pc+4. JAL at 0x40 with immJ=−8 → redirectPC=0x38.
- bltu/blt with rs1=0xFFFFFFFF, rs2=1: bltu not taken, blt taken. funct3=010 → illegalBranch=1, actualTaken=0, BHT unchanged.
- Assert reset while squashCount=1 → squashCount=0, and the next resolveValid is accepted.
